// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared game constants for the alien laser datapath: screen
//                edges, spaceship geometry, alien and laser sizes, colours and
//                the slot state encoding. Also holds a small helper that tests
//                |a - b| <= r without unsigned wrap.
//  Ports       : (package, none)
//  Options     : none here; see alien_laser_bank for ALIEN_LASER_LFSR_EN.
//  Revision    : 1.0  initial release
// ============================================================================
package game_pkg;

    localparam int COORD_W = 11;

    // Compare constants are 12 bits so that coordinate arithmetic can be
    // done one bit wider than the 11-bit coordinates and never wraps.
    localparam logic [11:0] SCREEN_LEFT        = 12'd0;
    localparam logic [11:0] SCREEN_RIGHT       = 12'd640;
    localparam logic [11:0] SCREEN_TOP         = 12'd60;
    localparam logic [11:0] SCREEN_BOTTOM      = 12'd480;
    localparam logic [11:0] SPACESHIP_TOP      = 12'd420;
    localparam logic [11:0] SPACESHIP_HALF_LEN = 12'd20;
    localparam logic [11:0] LASER_HALF_W       = 12'd1;
    localparam logic [11:0] LASER_HALF_H       = 12'd5;

    localparam logic [COORD_W-1:0] ALIEN_HEIGHT = 11'd16;

    localparam logic [7:0] COLOR_LASER = 8'h3F;
    localparam logic [7:0] COLOR_BLACK = 8'h00;

    localparam logic [1:0] MODE_PLAY = 2'd2;

    typedef enum logic {
        SLOT_IDLE   = 1'b0,
        SLOT_ACTIVE = 1'b1
    } slot_state_e;

    // True when |a - b| <= r, evaluated as (a + r >= b) && (a <= b + r) so
    // no subtraction can underflow.
    function automatic logic abs_within(input logic [11:0] a,
                                        input logic [11:0] b,
                                        input logic [11:0] r);
        return ((a + r) >= b) && (a <= (b + r));
    endfunction

endpackage
`default_nettype wire

// File: rtl/alien_laser_slot.sv
`default_nettype none
// ============================================================================
//  Module      : alien_laser_slot
//  Description : One alien laser: IDLE/ACTIVE state, registered centre
//                coordinates, retire decision (bottom, ship, player shot,
//                barrier) and the per-pixel hit test.
//  Ports       : clk, rst (async, active-low), clear (sync), tick (frame),
//                spawn + spawn_x/spawn_y (alien centre), ship/shot/barrier
//                hit inputs, pix_x/pix_y (VGA pixel);
//                outputs active, x, y, pix_hit.
//  Revision    : 1.0  initial release
// ============================================================================
module alien_laser_slot
    import game_pkg::*;
#(
    parameter int LASER_STEP = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               tick,
    input  logic               spawn,
    input  logic [COORD_W-1:0] spawn_x,
    input  logic [COORD_W-1:0] spawn_y,
    input  logic [COORD_W-1:0] ship_x,
    input  logic [COORD_W-1:0] shot_x,
    input  logic [COORD_W-1:0] shot_y,
    input  logic               shot_active,
    input  logic               barr_hit,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [9:0]         pix_y,
    output logic               active,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               pix_hit
);

    localparam logic [COORD_W-1:0] c_step = COORD_W'(LASER_STEP);

    slot_state_e        state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;

    logic [11:0] w_x, w_y;
    logic        w_hit_bottom, w_hit_ship, w_hit_shot, w_retire;

    assign w_x = {1'b0, x_q};
    assign w_y = {1'b0, y_q};

    assign w_hit_bottom = (w_y + {1'b0, c_step}) >= SCREEN_BOTTOM;
    assign w_hit_ship   = (w_y >= SPACESHIP_TOP)
                       && abs_within(w_x, {1'b0, ship_x}, SPACESHIP_HALF_LEN);
    // y >= shot_y - 5 rewritten as y + 5 >= shot_y to stay unsigned-safe.
    assign w_hit_shot   = shot_active
                       && ((w_y + LASER_HALF_H) >= {1'b0, shot_y})
                       && abs_within(w_x, {1'b0, shot_x}, LASER_HALF_W);
    assign w_retire     = w_hit_bottom || w_hit_ship || w_hit_shot || barr_hit;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        if (clear) begin
            state_d = SLOT_IDLE;
            x_d     = '0;
            y_d     = '0;
        end else if (tick) begin
            if (state_q == SLOT_ACTIVE) begin
                if (w_retire) begin
                    state_d = SLOT_IDLE;
                    x_d     = '0;
                    y_d     = '0;
                end else begin
                    y_d = y_q + c_step;
                end
            end else if (spawn) begin
                // Laser leaves from the bottom edge of the alien sprite.
                state_d = SLOT_ACTIVE;
                x_d     = spawn_x;
                y_d     = spawn_y + (ALIEN_HEIGHT >> 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SLOT_IDLE;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign active  = (state_q == SLOT_ACTIVE);
    assign x       = x_q;
    assign y       = y_q;
    assign pix_hit = active
                  && abs_within({1'b0, pix_x}, w_x, LASER_HALF_W)
                  && abs_within({2'b00, pix_y}, w_y, LASER_HALF_H);

endmodule
`default_nettype wire

// File: rtl/alien_laser_bank.sv
`default_nettype none
// ============================================================================
//  Module      : alien_laser_bank
//  Description : Bank of downward alien lasers, one slot per alien column.
//                Once per frame (pixel 0,0 in play mode) it advances/retires
//                the active lasers and, every fire period, spawns at most one
//                new laser from the first idle slot whose alien is alive.
//  Ports       : clk, rst (async, active-low), restart (sync clear), mode,
//                xCoord/yCoord (VGA pixel), alien_xCoord/alien_yCoord/
//                alien_alive, spaceship_xCoord, shot_xCoord/shot_yCoord/
//                shot_active, barr_hit;
//                outputs alien_laser_xCoord/alien_laser_yCoord (packed,
//                11 bits per slot), rgb (registered), is_alien_laser.
//  Options     : ALIEN_LASER_LFSR_EN - randomised scan start and fire period
//                from an 8-bit Galois LFSR; undefined = round-robin, fixed
//                period.
//  Revision    : 1.0  initial release
// ============================================================================
module alien_laser_bank
    import game_pkg::*;
#(
    parameter int NUM_LASERS  = 12,
    parameter int FIRE_PERIOD = 60,
    parameter int LASER_STEP  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          restart,
    input  logic [1:0]                    mode,
    input  logic [COORD_W-1:0]            xCoord,
    input  logic [9:0]                    yCoord,
    input  logic [COORD_W*NUM_LASERS-1:0] alien_xCoord,
    input  logic [COORD_W*NUM_LASERS-1:0] alien_yCoord,
    input  logic [NUM_LASERS-1:0]         alien_alive,
    input  logic [COORD_W-1:0]            spaceship_xCoord,
    input  logic [COORD_W-1:0]            shot_xCoord,
    input  logic [COORD_W-1:0]            shot_yCoord,
    input  logic                          shot_active,
    input  logic [NUM_LASERS-1:0]         barr_hit,
    output logic [COORD_W*NUM_LASERS-1:0] alien_laser_xCoord,
    output logic [COORD_W*NUM_LASERS-1:0] alien_laser_yCoord,
    output logic [7:0]                    rgb,
    output logic                          is_alien_laser
);

    localparam int             c_ptr_w  = (NUM_LASERS > 1) ? $clog2(NUM_LASERS) : 1;
    localparam logic [7:0]     c_reload = 8'(FIRE_PERIOD - 1);

    logic [7:0]            cnt_q, cnt_d;
    logic [c_ptr_w-1:0]    ptr_q, ptr_d;
    logic [7:0]            rgb_q, rgb_d;

    logic                  w_clear, w_tick, w_attempt, w_found;
    logic [c_ptr_w-1:0]    w_start, w_pick;
    logic [NUM_LASERS-1:0] w_active, w_pix_hit, w_spawn_sel;

`ifdef ALIEN_LASER_LFSR_EN
    localparam logic [7:0] c_lfsr_seed = 8'hA5;
    // Right-shifting Galois form of x^8 + x^6 + x^5 + x^4 + 1.
    localparam logic [7:0] c_lfsr_taps = 8'hB8;

    logic [7:0] lfsr_q, lfsr_d;

    assign w_start = c_ptr_w'(lfsr_q % 8'(NUM_LASERS));
`else
    assign w_start = ptr_q;
`endif

    assign w_clear   = restart || (mode != MODE_PLAY);
    assign w_tick    = (xCoord == '0) && (yCoord == '0) && (mode == MODE_PLAY);
    assign w_attempt = w_tick && (cnt_q == 8'd0);

    // Wrap-around scan from w_start for the first idle slot with a live
    // alien. Slots retiring on this tick are still ACTIVE here, so they
    // cannot be picked again in the same frame.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < NUM_LASERS; k++) begin
            idx = int'(w_start) + k;
            if (idx >= NUM_LASERS) begin
                idx = idx - NUM_LASERS;
            end
            if (!w_found && !w_active[idx] && alien_alive[idx]) begin
                w_found = 1'b1;
                w_pick  = c_ptr_w'(idx);
            end
        end
    end

    always_comb begin
        w_spawn_sel = '0;
        if (w_attempt && w_found && !w_clear) begin
            w_spawn_sel[w_pick] = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        ptr_d = ptr_q;
        rgb_d = is_alien_laser ? COLOR_LASER : COLOR_BLACK;
`ifdef ALIEN_LASER_LFSR_EN
        lfsr_d = lfsr_q;
`endif
        if (w_clear) begin
            cnt_d = c_reload;
            ptr_d = '0;
            rgb_d = COLOR_BLACK;
`ifdef ALIEN_LASER_LFSR_EN
            lfsr_d = c_lfsr_seed;
`endif
        end else if (w_tick) begin
`ifdef ALIEN_LASER_LFSR_EN
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? c_lfsr_taps : 8'h00);
`endif
            if (cnt_q == 8'd0) begin
`ifdef ALIEN_LASER_LFSR_EN
                cnt_d = 8'(FIRE_PERIOD / 2) + {3'b000, lfsr_q[4:0]};
`else
                cnt_d = c_reload;
`endif
                if (w_found) begin
                    if (int'(w_pick) == NUM_LASERS - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = w_pick + c_ptr_w'(1);
                    end
                end
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= c_reload;
            ptr_q <= '0;
            rgb_q <= COLOR_BLACK;
        end else begin
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
            rgb_q <= rgb_d;
        end
    end

`ifdef ALIEN_LASER_LFSR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= c_lfsr_seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    generate
        for (genvar i = 0; i < NUM_LASERS; i++) begin : g_slot
            alien_laser_slot #(
                .LASER_STEP (LASER_STEP)
            ) u_slot (
                .clk         (clk),
                .rst         (rst),
                .clear       (w_clear),
                .tick        (w_tick),
                .spawn       (w_spawn_sel[i]),
                .spawn_x     (alien_xCoord[COORD_W*i +: COORD_W]),
                .spawn_y     (alien_yCoord[COORD_W*i +: COORD_W]),
                .ship_x      (spaceship_xCoord),
                .shot_x      (shot_xCoord),
                .shot_y      (shot_yCoord),
                .shot_active (shot_active),
                .barr_hit    (barr_hit[i]),
                .pix_x       (xCoord),
                .pix_y       (yCoord),
                .active      (w_active[i]),
                .x           (alien_laser_xCoord[COORD_W*i +: COORD_W]),
                .y           (alien_laser_yCoord[COORD_W*i +: COORD_W]),
                .pix_hit     (w_pix_hit[i])
            );
        end
    endgenerate

    assign is_alien_laser = |w_pix_hit;
    assign rgb            = rgb_q;

endmodule
`default_nettype wire

// File: tb/tb_alien_laser_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alien_laser_bank
//  Description : Self-checking bench for alien_laser_bank. A default-period
//                instance covers spawn timing, movement, retire conditions,
//                clears and the pixel hit / rgb path; a short-period instance
//                fills all twelve slots for the scheduler corner cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alien_laser_bank;

    localparam int N = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          restart = 1'b0;
    logic [1:0]    mode = 2'd2;
    logic [10:0]   xCoord = 11'd5;
    logic [9:0]    yCoord = 10'd5;
    logic [131:0]  alien_xCoord = '0;
    logic [131:0]  alien_yCoord = '0;
    logic [11:0]   alien_alive = '0;
    logic [10:0]   spaceship_xCoord = 11'd600;
    logic [10:0]   shot_xCoord = '0;
    logic [10:0]   shot_yCoord = '0;
    logic          shot_active = 1'b0;
    logic [11:0]   barr_hit = '0;

    logic [131:0]  lx, ly, fx, fy;
    logic [7:0]    rgb, f_rgb;
    logic          hit, f_hit;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    alien_laser_bank dut (
        .clk(clk), .rst(rst), .restart(restart), .mode(mode),
        .xCoord(xCoord), .yCoord(yCoord),
        .alien_xCoord(alien_xCoord), .alien_yCoord(alien_yCoord),
        .alien_alive(alien_alive), .spaceship_xCoord(spaceship_xCoord),
        .shot_xCoord(shot_xCoord), .shot_yCoord(shot_yCoord),
        .shot_active(shot_active), .barr_hit(barr_hit),
        .alien_laser_xCoord(lx), .alien_laser_yCoord(ly),
        .rgb(rgb), .is_alien_laser(hit)
    );

    alien_laser_bank #(.FIRE_PERIOD(4)) dut_fast (
        .clk(clk), .rst(rst), .restart(restart), .mode(mode),
        .xCoord(xCoord), .yCoord(yCoord),
        .alien_xCoord(alien_xCoord), .alien_yCoord(alien_yCoord),
        .alien_alive(alien_alive), .spaceship_xCoord(spaceship_xCoord),
        .shot_xCoord(shot_xCoord), .shot_yCoord(shot_yCoord),
        .shot_active(shot_active), .barr_hit(barr_hit),
        .alien_laser_xCoord(fx), .alien_laser_yCoord(fy),
        .rgb(f_rgb), .is_alien_laser(f_hit)
    );

    typedef struct {
        logic [10:0] px;
        logic [9:0]  py;
        logic        exp_hit;
    } pix_vec_t;

    function automatic logic [10:0] slot(input logic [131:0] bus, input int i);
        return bus[11*i +: 11];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic ticks(input int n);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            xCoord = '0;
            yCoord = '0;
            @(negedge clk);
            xCoord = 11'd5;
            yCoord = 10'd5;
        end
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic set_alien(input int i, input logic [10:0] ax, input logic [10:0] ay);
        alien_xCoord[11*i +: 11] = ax;
        alien_yCoord[11*i +: 11] = ay;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        pix_vec_t vec [9];
        vec[0] = '{11'd300, 10'd118, 1'b1};
        vec[1] = '{11'd299, 10'd113, 1'b1};
        vec[2] = '{11'd301, 10'd123, 1'b1};
        vec[3] = '{11'd302, 10'd118, 1'b0};
        vec[4] = '{11'd298, 10'd118, 1'b0};
        vec[5] = '{11'd300, 10'd112, 1'b0};
        vec[6] = '{11'd300, 10'd124, 1'b0};
        vec[7] = '{11'd301, 10'd124, 1'b0};
        vec[8] = '{11'd150, 10'd118, 1'b0};

        // ---------------- reset state
        #12;
        chk("reset_x_bus", {31'd0, |lx}, 0);
        chk("reset_y_bus", {31'd0, |ly}, 0);
        chk("reset_rgb", {24'd0, rgb}, 0);
        chk("reset_hit", {31'd0, hit}, 0);

        // ---------------- only alien 7 alive: first spawn on tick 60
        alien_alive = 12'h080;
        set_alien(7, 11'd300, 11'd100);
        set_alien(2, 11'd50, 11'd40);
        set_alien(9, 11'd400, 11'd60);
        @(negedge clk);
        rst = 1'b1;
        ticks(59);
        chk("no_spawn_tick59", {21'd0, slot(ly, 7)}, 0);
        ticks(1);
        chk("spawn7_x", {21'd0, slot(lx, 7)}, 300);
        chk("spawn7_y", {21'd0, slot(ly, 7)}, 108);
        ticks(10);
        chk("move7_y", {21'd0, slot(ly, 7)}, 118);

        // ---------------- pixel hit table against laser at (300,118)
        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            xCoord = vec[v].px;
            yCoord = vec[v].py;
            #1;
            chk($sformatf("pix_hit[%0d]", v), {31'd0, hit}, {31'd0, vec[v].exp_hit});
            @(negedge clk);
            chk($sformatf("pix_rgb[%0d]", v), {24'd0, rgb}, vec[v].exp_hit ? 32'h3F : 32'h00);
        end
        @(negedge clk);
        xCoord = 11'd5;
        yCoord = 10'd5;

        // ---------------- pointer sits at 8: next spawn picks 9, not 2
        alien_alive = 12'h284;
        ticks(50);
        chk("ptr_spawn9_x", {21'd0, slot(lx, 9)}, 400);
        chk("ptr_spawn9_y", {21'd0, slot(ly, 9)}, 68);
        chk("ptr_skip2_y", {21'd0, slot(ly, 2)}, 0);
        chk("move7_y_168", {21'd0, slot(ly, 7)}, 168);

        // ---------------- restart clears everything
        do_restart();
        chk("restart_x_bus", {31'd0, |lx}, 0);
        chk("restart_y_bus", {31'd0, |ly}, 0);

        // ---------------- ship hit window
        alien_alive = 12'h010;
        set_alien(4, 11'd320, 11'd411);
        spaceship_xCoord = 11'd330;
        ticks(60);
        chk("ship_spawn_y", {21'd0, slot(ly, 4)}, 419);
        ticks(1);
        chk("ship_move_420", {21'd0, slot(ly, 4)}, 420);
        ticks(1);
        chk("ship_retire_x", {21'd0, slot(lx, 4)}, 0);
        chk("ship_retire_y", {21'd0, slot(ly, 4)}, 0);
        spaceship_xCoord = 11'd600;

        // ---------------- screen bottom
        do_restart();
        set_alien(4, 11'd100, 11'd462);
        ticks(60);
        chk("bottom_spawn_y", {21'd0, slot(ly, 4)}, 470);
        ticks(9);
        chk("bottom_479", {21'd0, slot(ly, 4)}, 479);
        ticks(1);
        chk("bottom_retire_y", {21'd0, slot(ly, 4)}, 0);
        chk("bottom_retire_x", {21'd0, slot(lx, 4)}, 0);

        // ---------------- player shot hit at |dx| = 1
        do_restart();
        set_alien(4, 11'd251, 11'd188);
        ticks(60);
        chk("shot_spawn_y", {21'd0, slot(ly, 4)}, 196);
        shot_xCoord = 11'd250;
        shot_yCoord = 11'd200;
        shot_active = 1'b1;
        ticks(1);
        chk("shot_retire_y", {21'd0, slot(ly, 4)}, 0);
        shot_active = 1'b0;

        // ---------------- player shot miss at |dx| = 3
        do_restart();
        set_alien(4, 11'd253, 11'd188);
        ticks(60);
        shot_active = 1'b1;
        ticks(1);
        chk("shot_miss_x", {21'd0, slot(lx, 4)}, 253);
        chk("shot_miss_y", {21'd0, slot(ly, 4)}, 197);
        shot_active = 1'b0;

        // ---------------- leaving play mode clears
        @(negedge clk);
        mode = 2'd1;
        @(negedge clk);
        chk("mode_clear_y", {21'd0, slot(ly, 4)}, 0);
        mode = 2'd2;

        // ---------------- all slots active (short-period instance)
        do_restart();
        alien_alive = 12'hFFF;
        for (int i = 0; i < N; i++) set_alien(i, 11'(20 + 40 * i), 11'd10);
        ticks(48);
        chk("full_slot0_y", {21'd0, slot(fy, 0)}, 62);
        chk("full_slot11_y", {21'd0, slot(fy, 11)}, 18);
        ticks(4);
        chk("full_nospawn_slot5_y", {21'd0, slot(fy, 5)}, 18 + 24 + 4);
        chk("full_nospawn_slot11_y", {21'd0, slot(fy, 11)}, 22);
        @(negedge clk);
        barr_hit = 12'h220;
        ticks(1);
        barr_hit = '0;
        chk("barr_retire5_y", {21'd0, slot(fy, 5)}, 0);
        chk("barr_retire9_y", {21'd0, slot(fy, 9)}, 0);
        chk("barr_keep4_y", {21'd0, slot(fy, 4)}, 18 + 28 + 5);
        ticks(3);
        chk("respawn5_x", {21'd0, slot(fx, 5)}, 220);
        chk("respawn5_y", {21'd0, slot(fy, 5)}, 18);
        chk("wait9_y", {21'd0, slot(fy, 9)}, 0);
        ticks(4);
        chk("respawn9_x", {21'd0, slot(fx, 9)}, 380);
        chk("respawn9_y", {21'd0, slot(fy, 9)}, 18);

        // ---------------- async reset mid-flight, then 60-tick first spawn
        do_restart();
        alien_alive = 12'h008;
        set_alien(3, 11'd200, 11'd292);
        ticks(60);
        chk("flight3_x", {21'd0, slot(lx, 3)}, 200);
        chk("flight3_y", {21'd0, slot(ly, 3)}, 300);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_x_bus", {31'd0, |lx}, 0);
        chk("async_rst_y_bus", {31'd0, |ly}, 0);
        @(negedge clk);
        rst = 1'b1;
        ticks(59);
        chk("rst_no_spawn59", {21'd0, slot(ly, 3)}, 0);
        ticks(1);
        chk("rst_spawn60_x", {21'd0, slot(lx, 3)}, 200);
        chk("rst_spawn60_y", {21'd0, slot(ly, 3)}, 300);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
